// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch: owns the PC, reads one word per instruction and hands it to decode.
// Optional response timeout is enabled by defining IFU_TIMEOUT_EN.
module ifu_fetch #(
  parameter int unsigned      WIDTH          = 32,
  parameter logic [WIDTH-1:0] RESET_PC       = WIDTH'(32'h8000_0000),
  parameter int unsigned      TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] next_pc,
  input  logic             next_pc_valid,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             imem_rsp_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             fetch_fault
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_RETIRE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [31:0]      inst_reg, inst_next;
  logic [WIDTH-1:0] inst_pc_reg, inst_pc_next;
  logic             fault_reg, fault_next;
  logic             misaligned;
  logic             timeout_hit;

  assign misaligned = |pc_reg[1:0];

`ifdef IFU_TIMEOUT_EN
  localparam int unsigned TIMER_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TIMER_W-1:0] timer_reg;

  // Held at zero outside S_WAIT, so every entry into S_WAIT starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || state_reg != S_WAIT) begin
      timer_reg <= '0;
    end else if (!imem_rsp_valid) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  assign timeout_hit = (state_reg == S_WAIT) && !imem_rsp_valid &&
                       (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_REQ;
      pc_reg      <= RESET_PC;
      inst_reg    <= NOP_INST;
      inst_pc_reg <= RESET_PC;
      fault_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      inst_reg    <= inst_next;
      inst_pc_reg <= inst_pc_next;
      fault_reg   <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_REQ: begin
        if (misaligned) begin
          state_next = S_HOLD;
        end else if (imem_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid || timeout_hit) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          state_next = next_pc_valid ? S_REQ : S_RETIRE;
        end
      end
      S_RETIRE: begin
        if (next_pc_valid) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  // The PC moves only on a retire event; the instruction latch only on entry to S_HOLD.
  always_comb begin
    pc_next      = pc_reg;
    inst_next    = inst_reg;
    inst_pc_next = inst_pc_reg;
    fault_next   = fault_reg;
    case (state_reg)
      S_REQ: begin
        if (misaligned) begin
          inst_next    = NOP_INST;
          inst_pc_next = pc_reg;
          fault_next   = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          inst_next    = imem_rsp_data;
          inst_pc_next = pc_reg;
          fault_next   = imem_rsp_err;
        end else if (timeout_hit) begin
          inst_next    = NOP_INST;
          inst_pc_next = pc_reg;
          fault_next   = 1'b1;
        end
      end
      S_HOLD: begin
        if (inst_ready && next_pc_valid) begin
          pc_next = next_pc;
        end
      end
      S_RETIRE: begin
        if (next_pc_valid) begin
          pc_next = next_pc;
        end
      end
      default: ;
    endcase
  end

  // Request is masked while rst is high so nothing is issued before reset releases.
  always_comb begin
    imem_req_valid = !rst && (state_reg == S_REQ) && !misaligned;
    imem_req_addr  = pc_reg;
    inst_valid     = (state_reg == S_HOLD);
    fetch_fault    = (state_reg == S_HOLD) && fault_reg;
    inst           = inst_reg;
    inst_pc        = inst_pc_reg;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: bench plays memory, decode and retire; expectations come from per-instruction rules.
module tb_ifu_fetch;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        next_pc_valid;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifu_fetch #(
    .WIDTH         (32),
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .next_pc       (next_pc),
    .next_pc_valid (next_pc_valid),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .fetch_fault   (fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    next_pc_valid  = 1'b0;
    next_pc        = $urandom;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    imem_rsp_err   = 1'($urandom_range(0, 1));
  endtask

  // Inputs the fetch unit must ignore in the current state.
  task automatic noise(input bit rsp_ok, input bit np_ok);
    quiet();
    if (rsp_ok) imem_rsp_valid = 1'($urandom_range(0, 1));
    if (np_ok)  next_pc_valid  = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_inst(input string tag, input logic [31:0] e_inst, input logic [31:0] e_pc,
                          input logic e_fault);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
    chk({tag, "_inst"}, inst, e_inst);
    chk({tag, "_pc"}, inst_pc, e_pc);
    chk({tag, "_fault"}, 32'(fetch_fault), 32'(e_fault));
    $display("txn pc=%h inst=%h fault=%0d", inst_pc, inst, fetch_fault);
  endtask

  // One complete instruction: request, response, decode handshake, retire.
  task automatic fetch_one(input logic [31:0] exp_pc, input int req_stall, input int rsp_delay,
                           input logic err, input logic [31:0] data, input int dec_stall,
                           input bit np_same, input logic [31:0] np, input int retire_delay);
    bit          mis;
    logic [31:0] e_inst;
    logic        e_fault;
    mis     = (exp_pc[1:0] != 2'b00);
    e_inst  = mis ? NOP : data;
    e_fault = mis | err;
    if (mis) begin
      noise(1, 1);
      chk("req_valid_mis", 32'(imem_req_valid), 32'd0);
      chk("inst_valid_mis_pre", 32'(inst_valid), 32'd0);
      tick();
      quiet();
    end else begin
      imem_req_ready = 1'b0;
      for (int i = 0; i < req_stall; i++) begin
        noise(1, 1);
        chk("req_valid_stall", 32'(imem_req_valid), 32'd1);
        chk("req_addr_stall", imem_req_addr, exp_pc);
        tick();
      end
      imem_req_ready = 1'b1;
      noise(1, 1);
      chk("req_valid", 32'(imem_req_valid), 32'd1);
      chk("req_addr", imem_req_addr, exp_pc);
      tick();
      imem_req_ready = 1'b0;
      quiet();
      for (int i = 0; i < rsp_delay; i++) begin
        noise(0, 1);
        chk("req_valid_wait", 32'(imem_req_valid), 32'd0);
        chk("inst_valid_wait", 32'(inst_valid), 32'd0);
        tick();
      end
      quiet();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      imem_rsp_err   = err;
      chk("req_valid_rsp", 32'(imem_req_valid), 32'd0);
      chk("inst_valid_rsp", 32'(inst_valid), 32'd0);
      tick();
      quiet();
    end
    chk_inst("hold", e_inst, exp_pc, e_fault);
    for (int i = 0; i < dec_stall; i++) begin
      inst_ready = 1'b0;
      noise(1, 1);
      tick();
      chk_inst("held", e_inst, exp_pc, e_fault);
    end
    quiet();
    inst_ready    = 1'b1;
    next_pc_valid = np_same;
    next_pc       = np;
    tick();
    inst_ready = 1'b0;
    quiet();
    chk("inst_valid_drop", 32'(inst_valid), 32'd0);
    if (!np_same) begin
      for (int i = 0; i < retire_delay; i++) begin
        noise(1, 0);
        chk("req_valid_retire", 32'(imem_req_valid), 32'd0);
        chk("inst_valid_retire", 32'(inst_valid), 32'd0);
        tick();
      end
      quiet();
      next_pc_valid = 1'b1;
      next_pc       = np;
      tick();
      quiet();
    end
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] np;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    quiet();
    repeat (3) tick();

    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, RST_PC);
    rst = 1'b0;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, RST_PC);

    // Directed: best-case fetch, decode stall, same-cycle retire.
    fetch_one(RST_PC, 0, 0, 1'b0, 32'h0000_0513, 4, 1, 32'h8000_0004, 0);
    // Request stall of 3 cycles, then retire to a misaligned PC.
    fetch_one(32'h8000_0004, 3, 1, 1'b0, 32'h0041_0093, 0, 0, 32'h8000_0006, 2);
    fetch_one(32'h8000_0006, 0, 0, 1'b0, 32'h0, 1, 0, 32'h8000_0008, 1);
    // Bus error keeps the returned data.
    fetch_one(32'h8000_0008, 0, 2, 1'b1, 32'hdead_beef, 0, 1, 32'h8000_000c, 0);

    // Reset landing in S_WAIT.
    imem_req_ready = 1'b1;
    chk("pre_rst_addr", imem_req_addr, 32'h8000_000c);
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("midrst_req_addr", imem_req_addr, RST_PC);
    chk("midrst_inst_valid", 32'(inst_valid), 32'd0);

    // Randomized run: each instruction's outcome follows from its PC, data and error bit.
    pc = RST_PC;
    for (int n = 0; n < 40; n++) begin
      np = RST_PC + 32'(4 * $urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) np = np + 32'd2;
      fetch_one(pc, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 7) == 0), $urandom, $urandom_range(0, 3),
                1'($urandom_range(0, 1)), np, $urandom_range(0, 3));
      pc = np;
    end

`ifdef IFU_TIMEOUT_EN
    // Steer to an aligned PC, then let the memory stay silent.
    if (pc[1:0] != 2'b00) begin
      fetch_one(pc, 0, 0, 1'b0, 32'h0, 0, 1, RST_PC + 32'h40, 0);
      pc = RST_PC + 32'h40;
    end
    imem_req_ready = 1'b1;
    chk("to_req_addr", imem_req_addr, pc);
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_inst_valid", 32'(inst_valid), 32'd0);
      tick();
    end
    chk_inst("timeout", NOP, pc, 1'b1);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    tick();
    quiet();
    chk_inst("late_rsp", NOP, pc, 1'b1);
    inst_ready    = 1'b1;
    next_pc_valid = 1'b1;
    next_pc       = RST_PC;
    tick();
    inst_ready = 1'b0;
    quiet();
    chk("to_next_addr", imem_req_addr, RST_PC);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
